// File: rtl/hamming_dma_if.sv
// Program handshake and data-memory port between the core side and the Hamming(15,11) coprocessor.
interface hamming_dma_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          mode;
  logic          ack;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic [7:0]    corr_cnt;

  modport master (
    output req, mode, mem_rd_data,
    input  ack, busy, mem_addr, mem_wr_en, mem_wr_data, corr_cnt
  );

  modport slave (
    input  req, mode, mem_rd_data,
    output ack, busy, mem_addr, mem_wr_en, mem_wr_data, corr_cnt
  );
endinterface

// File: rtl/hamming_dma.sv
// Hamming(15,11) coprocessor: walks NMSG two-byte messages in data memory and
// writes encoded (mode 0) or corrected/stripped (mode 1) results to a destination region.
module hamming_dma #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int NMSG    = 15,
  parameter int SRC_ENC = 0,
  parameter int DST_ENC = 30,
  parameter int SRC_DEC = 64,
  parameter int DST_DEC = 94
) (
  input logic         clk,
  input logic         reset,
  hamming_dma_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_mode;
  logic [6:0]    r_idx;
  logic [7:0]    r_lo;
  logic [6:0]    r_hi;
  logic [7:0]    r_corrCnt;

  logic          w_accept;
  logic          w_last;
  logic [AW-1:0] w_srcBase;
  logic [AW-1:0] w_dstBase;
  logic [AW-1:0] w_off;
  logic [11:1]   w_d;
  logic [15:1]   w_encCw;
  logic [15:1]   w_decCw;
  logic [3:0]    w_syn;
  logic [11:1]   w_flipD;
  logic [11:1]   w_decD;
  logic [7:0]    w_loByte;
  logic [7:0]    w_hiByte;

  assign w_accept  = (r_state == IDLE) && bus.req;
  assign w_last    = (r_idx == 7'(NMSG - 1));
  assign w_srcBase = r_mode ? AW'(SRC_DEC) : AW'(SRC_ENC);
  assign w_dstBase = r_mode ? AW'(DST_DEC) : AW'(DST_ENC);
  assign w_off     = AW'({r_idx, 1'b0});

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req) w_next = RD_LO;
      RD_LO:   w_next = RD_HI;
      RD_HI:   w_next = CAP;
      CAP:     w_next = WR_LO;
      WR_LO:   w_next = WR_HI;
      WR_HI:   w_next = w_last ? DONE : RD_LO;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so lo lands during RD_HI and hi during CAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode    <= 1'b0;
      r_idx     <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_corrCnt <= '0;
    end else begin
      if (w_accept) begin
        r_mode <= bus.mode;
        r_idx  <= '0;
        if (bus.mode) r_corrCnt <= '0;
      end
      if (r_state == RD_HI) r_lo <= bus.mem_rd_data[7:0];
      if (r_state == CAP)   r_hi <= bus.mem_rd_data[6:0];
      if (r_state == WR_HI) begin
        if (!w_last) r_idx <= r_idx + 7'd1;
        if (r_mode && (w_syn != 4'd0) && (r_corrCnt != 8'hFF)) r_corrCnt <= r_corrCnt + 8'd1;
      end
    end
  end

  assign w_d     = {r_hi[2:0], r_lo};
  assign w_encCw = {w_d[11:5], ^w_d[11:5], w_d[4:2], ^{w_d[11:8], w_d[4:2]}, w_d[1],
                    w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1],
                    w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5] ^ w_d[4] ^ w_d[2] ^ w_d[1]};

  // Each syndrome bit is the parity of the positions whose index has that bit set.
  assign w_decCw  = {r_hi[6:0], r_lo};
  assign w_syn[0] = ^{w_decCw[15], w_decCw[13], w_decCw[11], w_decCw[9],
                      w_decCw[7], w_decCw[5], w_decCw[3], w_decCw[1]};
  assign w_syn[1] = ^{w_decCw[15:14], w_decCw[11:10], w_decCw[7:6], w_decCw[3:2]};
  assign w_syn[2] = ^{w_decCw[15:12], w_decCw[7:4]};
  assign w_syn[3] = ^w_decCw[15:8];

  always_comb begin
    w_flipD = '0;
    case (w_syn)
      4'd3:    w_flipD = 11'h001;
      4'd5:    w_flipD = 11'h002;
      4'd6:    w_flipD = 11'h004;
      4'd7:    w_flipD = 11'h008;
      4'd9:    w_flipD = 11'h010;
      4'd10:   w_flipD = 11'h020;
      4'd11:   w_flipD = 11'h040;
      4'd12:   w_flipD = 11'h080;
      4'd13:   w_flipD = 11'h100;
      4'd14:   w_flipD = 11'h200;
      4'd15:   w_flipD = 11'h400;
      default: w_flipD = '0;
    endcase
  end

  assign w_decD   = {w_decCw[15:9], w_decCw[7:5], w_decCw[3]} ^ w_flipD;
  assign w_loByte = r_mode ? w_decD[8:1] : w_encCw[8:1];
  assign w_hiByte = r_mode ? {5'b0, w_decD[11:9]} : {1'b0, w_encCw[15:9]};

  always_comb begin
    bus.ack         = 1'b0;
    bus.busy        = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    case (r_state)
      RD_LO: begin
        bus.busy     = 1'b1;
        bus.mem_addr = w_srcBase + w_off;
      end
      RD_HI: begin
        bus.busy     = 1'b1;
        bus.mem_addr = w_srcBase + w_off + AW'(1);
      end
      CAP:   bus.busy = 1'b1;
      WR_LO: begin
        bus.busy        = 1'b1;
        bus.mem_addr    = w_dstBase + w_off;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = DW'(w_loByte);
      end
      WR_HI: begin
        bus.busy        = 1'b1;
        bus.mem_addr    = w_dstBase + w_off + AW'(1);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = DW'(w_hiByte);
      end
      DONE:    bus.ack = 1'b1;
      default: ;
    endcase
  end

  assign bus.corr_cnt = r_corrCnt;

endmodule

// File: tb/tb_hamming_dma.sv
// Self-checking bench for hamming_dma: random messages against a generic Hamming(15,11)
// reference model, plus handshake timing, ignored requests and mid-run reset.
module tb_hamming_dma;
  localparam int NMSG    = 15;
  localparam int SRC_ENC = 0;
  localparam int DST_ENC = 30;
  localparam int SRC_DEC = 64;
  localparam int DST_DEC = 94;
  localparam int NO_CYCLE = -10;

  logic clk = 1'b0;
  logic reset;
  logic tbWrEn;
  logic [7:0] tbAddr;
  logic [7:0] tbData;

  int checkCount = 0;
  int failCount  = 0;
  int wrCount    = 0;
  int ackCount   = 0;

  logic [7:0]  mem [256];
  logic [10:0] origData [NMSG];
  logic [7:0]  srcLo [NMSG];
  logic [7:0]  srcHi [NMSG];

  hamming_dma_if #(.AW(8), .DW(8)) bus ();

  hamming_dma #(
    .AW(8), .DW(8), .NMSG(NMSG),
    .SRC_ENC(SRC_ENC), .DST_ENC(DST_ENC), .SRC_DEC(SRC_DEC), .DST_DEC(DST_DEC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read data memory; the bench preloads it through tbWrEn while the DUT is idle.
  always @(posedge clk) begin
    bus.mem_rd_data <= mem[bus.mem_addr];
    if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wr_data;
    else if (tbWrEn)   mem[tbAddr] = tbData;
  end

  // Counts write strobes and ack pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_wr_en) wrCount <= wrCount + 1;
    if (bus.ack)       ackCount <= ackCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Generic Hamming rule: data fills the non-power-of-two positions in order,
  // parity bit p covers every position whose index has bit p set.
  function automatic logic [14:0] refEncode(input logic [10:0] d);
    logic [15:0] c;
    int j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        j++;
      end
    for (int p = 1; p < 16; p = p * 2)
      for (int pos = 1; pos < 16; pos++)
        if (((pos & p) != 0) && (pos != p)) c[p] = c[p] ^ c[pos];
    return c[15:1];
  endfunction

  // Returns {corrected, data}.
  function automatic logic [11:0] refDecode(input logic [14:0] cw);
    logic [15:0] c;
    logic [10:0] d;
    int syn;
    int j;
    c = {cw, 1'b0};
    syn = 0;
    for (int pos = 1; pos < 16; pos++)
      if (c[pos]) syn = syn ^ pos;
    if (syn != 0) c[syn] = ~c[syn];
    j = 0;
    d = '0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[j] = c[pos];
        j++;
      end
    return {syn != 0, d};
  endfunction

  task automatic pokeByte(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    tbWrEn = 1'b1;
    tbAddr = addr;
    tbData = data;
    @(negedge clk);
    tbWrEn = 1'b0;
  endtask

  task automatic loadRegion(input int base);
    for (int i = 0; i < NMSG; i++) begin
      pokeByte(8'(base + 2 * i), srcLo[i]);
      pokeByte(8'(base + 2 * i + 1), srcHi[i]);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".ack"}, 32'(bus.ack), 0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 0);
    checkOutput({tag, ".wrEn"}, 32'(bus.mem_wr_en), 0);
    checkOutput({tag, ".addr"}, 32'(bus.mem_addr), 0);
    checkOutput({tag, ".wrData"}, 32'(bus.mem_wr_data), 0);
    checkOutput({tag, ".corrCnt"}, 32'(bus.corr_cnt), 0);
  endtask

  // Starts a run, re-pulses req at cycles pulseA/pulseB, optionally resets at cycle resetAt,
  // and watches a bounded window; cycle 1 is the first cycle after the accepting edge.
  task automatic applyStimulus(input bit m, input int pulseA, input int pulseB, input int resetAt,
                               output int ackAt, output int acks, output int writes);
    int ack0;
    int wr0;
    @(negedge clk);
    ack0 = ackCount;
    wr0  = wrCount;
    bus.mode = m;
    bus.req  = 1'b1;
    ackAt = -1;
    for (int n = 1; n <= 5 * NMSG + 10; n++) begin
      @(negedge clk);
      bus.req = (n == pulseA) || (n == pulseB);
      if (bus.ack && (ackAt < 0)) ackAt = n;
      if (n == resetAt) reset = 1'b1;
      if (n == resetAt + 1) begin
        checkResetOutputs("midReset");
        reset = 1'b0;
      end
    end
    @(negedge clk);
    acks   = ackCount - ack0;
    writes = wrCount - wr0;
  endtask

  task automatic checkRun(input string tag, input int ackAt, input int acks, input int writes);
    checkOutput({tag, ".ackCycle"}, 32'(ackAt), 5 * NMSG + 1);
    checkOutput({tag, ".ackCount"}, 32'(acks), 1);
    checkOutput({tag, ".writes"}, 32'(writes), 2 * NMSG);
    checkOutput({tag, ".busyAfter"}, 32'(bus.busy), 0);
  endtask

  task automatic checkEncode(input string tag);
    logic [14:0] cw;
    for (int i = 0; i < NMSG; i++) begin
      cw = refEncode({srcHi[i][2:0], srcLo[i]});
      checkOutput($sformatf("%s.lo%0d", tag, i), 32'(mem[DST_ENC + 2 * i]), 32'(cw[7:0]));
      checkOutput($sformatf("%s.hi%0d", tag, i), 32'(mem[DST_ENC + 2 * i + 1]), 32'({1'b0, cw[14:8]}));
    end
  endtask

  task automatic checkDecode(input string tag, output int corr);
    logic [11:0] r;
    corr = 0;
    for (int i = 0; i < NMSG; i++) begin
      r = refDecode({srcHi[i][6:0], srcLo[i]});
      if (r[11]) corr++;
      checkOutput($sformatf("%s.lo%0d", tag, i), 32'(mem[DST_DEC + 2 * i]), 32'(r[7:0]));
      checkOutput($sformatf("%s.hi%0d", tag, i), 32'(mem[DST_DEC + 2 * i + 1]), 32'({5'b0, r[10:8]}));
    end
  endtask

  task automatic newEncodeSource();
    for (int i = 0; i < NMSG; i++) begin
      origData[i] = 11'($urandom);
      srcLo[i] = origData[i][7:0];
      srcHi[i] = {5'($urandom), origData[i][10:8]};
    end
  endtask

  initial begin
    int ackAt, acks, writes, corr;
    logic [14:0] cw;

    reset  = 1'b1;
    bus.req  = 1'b0;
    bus.mode = 1'b0;
    tbWrEn = 1'b0;
    tbAddr = '0;
    tbData = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;

    $display("[TB] encode run with directed and random messages, extra req pulses");
    newEncodeSource();
    origData[0] = 11'h000; srcLo[0] = 8'h00; srcHi[0] = {5'($urandom), 3'h0};
    origData[1] = 11'h7FF; srcLo[1] = 8'hFF; srcHi[1] = {5'($urandom), 3'h7};
    origData[2] = 11'h001; srcLo[2] = 8'h01; srcHi[2] = {5'($urandom), 3'h0};
    loadRegion(SRC_ENC);
    applyStimulus(1'b0, 10, 76, NO_CYCLE, ackAt, acks, writes);
    checkRun("enc", ackAt, acks, writes);
    checkEncode("enc");
    checkOutput("enc.const0lo", 32'(mem[DST_ENC + 0]), 32'h00);
    checkOutput("enc.const0hi", 32'(mem[DST_ENC + 1]), 32'h00);
    checkOutput("enc.const1lo", 32'(mem[DST_ENC + 2]), 32'hFF);
    checkOutput("enc.const1hi", 32'(mem[DST_ENC + 3]), 32'h7F);
    checkOutput("enc.const2lo", 32'(mem[DST_ENC + 4]), 32'h07);
    checkOutput("enc.const2hi", 32'(mem[DST_ENC + 5]), 32'h00);

    $display("[TB] decode run on the encoder output plus directed codewords");
    for (int i = 0; i < NMSG; i++) begin
      srcLo[i] = mem[DST_ENC + 2 * i];
      srcHi[i] = {1'($urandom), mem[DST_ENC + 2 * i + 1][6:0]};
    end
    srcLo[0] = 8'h07; srcHi[0] = 8'h00;
    srcLo[1] = 8'hFF; srcHi[1] = 8'h7F;
    srcLo[2] = 8'h03; srcHi[2] = 8'h00;
    loadRegion(SRC_DEC);
    applyStimulus(1'b1, NO_CYCLE, NO_CYCLE, NO_CYCLE, ackAt, acks, writes);
    checkRun("dec", ackAt, acks, writes);
    checkDecode("dec", corr);
    checkOutput("dec.corrModel", 32'(bus.corr_cnt), 32'(corr));
    checkOutput("dec.corrConst", 32'(bus.corr_cnt), 1);
    checkOutput("dec.const0lo", 32'(mem[DST_DEC + 0]), 32'h01);
    checkOutput("dec.const0hi", 32'(mem[DST_DEC + 1]), 32'h00);
    checkOutput("dec.const1lo", 32'(mem[DST_DEC + 2]), 32'hFF);
    checkOutput("dec.const1hi", 32'(mem[DST_DEC + 3]), 32'h07);
    checkOutput("dec.const2lo", 32'(mem[DST_DEC + 4]), 32'h01);
    checkOutput("dec.const2hi", 32'(mem[DST_DEC + 5]), 32'h00);
    for (int i = 3; i < NMSG; i++)
      checkOutput($sformatf("roundTrip%0d", i),
                  32'({mem[DST_DEC + 2 * i + 1][2:0], mem[DST_DEC + 2 * i]}), 32'(origData[i]));

    $display("[TB] decode run with every message hit at a different bit position");
    for (int i = 0; i < NMSG; i++) begin
      cw = refEncode(origData[i]) ^ (15'h1 << i);
      srcLo[i] = cw[7:0];
      srcHi[i] = {1'b0, cw[14:8]};
    end
    loadRegion(SRC_DEC);
    applyStimulus(1'b1, NO_CYCLE, NO_CYCLE, NO_CYCLE, ackAt, acks, writes);
    checkRun("fix", ackAt, acks, writes);
    checkDecode("fix", corr);
    checkOutput("fix.corrCnt", 32'(bus.corr_cnt), 15);
    for (int i = 0; i < NMSG; i++)
      checkOutput($sformatf("fix.data%0d", i),
                  32'({mem[DST_DEC + 2 * i + 1][2:0], mem[DST_DEC + 2 * i]}), 32'(origData[i]));

    $display("[TB] encode run must leave corr_cnt untouched");
    newEncodeSource();
    loadRegion(SRC_ENC);
    applyStimulus(1'b0, NO_CYCLE, NO_CYCLE, NO_CYCLE, ackAt, acks, writes);
    checkRun("enc2", ackAt, acks, writes);
    checkEncode("enc2");
    checkOutput("enc2.corrKept", 32'(bus.corr_cnt), 15);

    $display("[TB] reset at cycle 20 of an encode run");
    newEncodeSource();
    loadRegion(SRC_ENC);
    applyStimulus(1'b0, NO_CYCLE, NO_CYCLE, 20, ackAt, acks, writes);
    checkOutput("rst.ackCount", 32'(acks), 0);
    checkOutput("rst.writes", 32'(writes), 8);
    checkOutput("rst.busyAfter", 32'(bus.busy), 0);

    $display("[TB] full encode run after the reset");
    newEncodeSource();
    loadRegion(SRC_ENC);
    applyStimulus(1'b0, NO_CYCLE, NO_CYCLE, NO_CYCLE, ackAt, acks, writes);
    checkRun("enc3", ackAt, acks, writes);
    checkEncode("enc3");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
